// File: rtl/gx_window_gen.sv
// rtl/gx_window_gen.sv - 3x3 raster window generator feeding the Sobel Gx stage
module gx_window_gen #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 15,
  parameter int IMG_H = 15,
  parameter int IDX_W = $clog2((IMG_W-2)*(IMG_H-2))
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [9*PIX_W-1:0] out_win,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic {FILL, STREAM} state_t;

  state_t           state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];
  logic [PIX_W-1:0] top_a, mid_a, bot_a;
  logic [PIX_W-1:0] top_b, mid_b, bot_b;
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic             accept, last_col, last_row, emit;
  logic [9*PIX_W-1:0] win_next;

  assign in_ready = Reset && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last_col = (col == CW'(IMG_W-1));
  assign last_row = (row == RW'(IMG_H-1));
  assign lb1_rd   = lb1[col];
  assign lb2_rd   = lb2[col];
  // Gating on col>=2 keeps the two shifted columns from the previous row out of any window.
  assign emit     = accept && (state == STREAM) && (col >= CW'(2));

  // Column a is c-2, column b is c-1; p1 lands in the least significant tap.
  assign win_next = {in_pixel, bot_b, bot_a,
                     lb1_rd,   mid_b, mid_a,
                     lb2_rd,   top_b, top_a};

  always_ff @(posedge Clk) begin
    if (accept) begin
      lb2[col] <= lb1_rd;
      lb1[col] <= in_pixel;
      top_a    <= top_b;
      mid_a    <= mid_b;
      bot_a    <= bot_b;
      top_b    <= lb2_rd;
      mid_b    <= lb1_rd;
      bot_b    <= in_pixel;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= FILL;
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_win    <= '0;
      out_idx    <= '0;
    end else begin
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      case (state)
        FILL:
          if (accept && last_col && (row == RW'(1))) state <= STREAM;
        STREAM:
          if (accept && last_col && last_row) state <= FILL;
        default:
          state <= FILL;
      endcase

      if (emit) begin
        out_valid  <= 1'b1;
        out_win    <= win_next;
        out_idx    <= IDX_W'((int'(row) - 2) * (IMG_W - 2) + int'(col) - 2);
        frame_done <= last_col && last_row;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gx_window_gen.sv
// tb/tb_gx_window_gen.sv - scoreboard bench for gx_window_gen
module tb_gx_window_gen;
  localparam int PIX_W = 8;
  localparam int IMG_W = 15;
  localparam int IMG_H = 15;
  localparam int IDX_W = 8;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PIX_W-1:0]   in_pixel = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [9*PIX_W-1:0] out_win;
  logic [IDX_W-1:0]   out_idx;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               frame_done;

  gx_window_gen #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .IDX_W(IDX_W)) dut (
    .Clk(clk), .Reset(rst_n), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .out_win(out_win), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9*PIX_W-1:0] win;
    logic [IDX_W-1:0]   idx;
    logic               fd;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  int   m_r = 0, m_c = 0, acc_cnt = 0;
  logic [PIX_W-1:0] img [IMG_H][IMG_W];
  logic exp_valid = 1'b0;
  logic prev_stall = 1'b0;
  logic [9*PIX_W-1:0] held_win;
  logic [IDX_W-1:0]   held_idx;
  logic               held_fd;
  logic obs_valid, obs_fd, obs_in_ready;
  logic [9*PIX_W-1:0] obs_win;
  logic [IDX_W-1:0]   obs_idx;
  int   win_cnt, fd_cnt, last_idx, acc_at_idx0;
  logic last_fd;
  logic [9*PIX_W-1:0] win_idx0, win_idx13;

  function automatic logic [PIX_W-1:0] ramp(int r, int c);
    return PIX_W'((r * IMG_W + c) % 256);
  endfunction

  function automatic logic [9*PIX_W-1:0] pack9(int p1, int p2, int p3, int p4, int p5,
                                               int p6, int p7, int p8, int p9);
    return {PIX_W'(p9), PIX_W'(p8), PIX_W'(p7), PIX_W'(p6), PIX_W'(p5),
            PIX_W'(p4), PIX_W'(p3), PIX_W'(p2), PIX_W'(p1)};
  endfunction

  task automatic cycle();
    exp_t e;
    logic emit_now;
    @(negedge clk);
    obs_valid = out_valid; obs_win = out_win; obs_idx = out_idx;
    obs_fd = frame_done; obs_in_ready = in_ready;
    emit_now = 1'b0;
    if (!rst_n) begin
      checks++;
      if (in_ready !== 1'b0) $display("FAIL in_ready_in_reset got %b want 0", in_ready);
      else passed++;
      sb_q.delete();
      m_r = 0; m_c = 0;
      prev_stall = 1'b0;
      exp_valid = 1'b0;
    end else begin
      checks++;
      if (out_valid !== exp_valid) $display("FAIL out_valid got %b want %b", out_valid, exp_valid);
      else passed++;
      checks++;
      if (in_ready !== (!exp_valid || out_ready))
        $display("FAIL in_ready got %b want %b", in_ready, (!exp_valid || out_ready));
      else passed++;
      if (prev_stall) begin
        checks++;
        if (out_win !== held_win || out_idx !== held_idx || frame_done !== held_fd)
          $display("FAIL stall_hold got %h/%0d/%b want %h/%0d/%b",
                   out_win, out_idx, frame_done, held_win, held_idx, held_fd);
        else passed++;
      end
      prev_stall = out_valid && !out_ready;
      held_win = out_win; held_idx = out_idx; held_fd = frame_done;
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL unexpected_window got idx %0d want none", out_idx);
        end else begin
          passed++;
          e = sb_q.pop_front();
          checks++;
          if (out_win !== e.win) $display("FAIL win got %h want %h", out_win, e.win);
          else passed++;
          checks++;
          if (out_idx !== e.idx) $display("FAIL idx got %0d want %0d", out_idx, e.idx);
          else passed++;
          checks++;
          if (frame_done !== e.fd) $display("FAIL frame_done got %b want %b", frame_done, e.fd);
          else passed++;
          win_cnt++;
          if (frame_done === 1'b1) fd_cnt++;
          last_idx = int'(out_idx);
          last_fd = frame_done;
          if (e.idx == 0) begin win_idx0 = out_win; acc_at_idx0 = m_r * IMG_W + m_c; end
          if (e.idx == 13) win_idx13 = out_win;
        end
      end
      if (in_valid && in_ready) begin
        img[m_r][m_c] = in_pixel;
        acc_cnt++;
        if (m_r >= 2 && m_c >= 2) begin
          emit_now = 1'b1;
          for (int k = 0; k < 9; k++)
            e.win[k*PIX_W +: PIX_W] = img[m_r - 2 + k / 3][m_c - 2 + k % 3];
          e.idx = IDX_W'((m_r - 2) * (IMG_W - 2) + (m_c - 2));
          e.fd  = (m_r == IMG_H - 1) && (m_c == IMG_W - 1);
          sb_q.push_back(e);
        end
        if (m_c == IMG_W - 1) begin
          m_c = 0;
          m_r = (m_r == IMG_H - 1) ? 0 : m_r + 1;
        end else begin
          m_c++;
        end
      end
      exp_valid = emit_now || (exp_valid && !out_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_pixels(int n, int pct);
    int target = acc_cnt + n;
    int budget = n * 20 + 100;
    out_ready = 1'b1;
    while (acc_cnt < target && budget > 0) begin
      in_valid = ($urandom_range(99) < pct);
      in_pixel = ramp(m_r, m_c);
      cycle();
      budget--;
    end
    checks++;
    if (acc_cnt < target) $display("FAIL accept_timeout got %0d want %0d", acc_cnt, target);
    else passed++;
  endtask

  task automatic drain(int k);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < k; i++) cycle();
    checks++;
    if (sb_q.size() != 0) $display("FAIL drain_left got %0d want 0", sb_q.size());
    else passed++;
  endtask

  task automatic clear_stats();
    win_cnt = 0; fd_cnt = 0; last_idx = -1; last_fd = 1'b0; acc_at_idx0 = -1;
    win_idx0 = '0; win_idx13 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_pixel = 8'hA5;
    cycle();
    cycle();
    rst_n = 1'b1;
    in_valid = 1'b0;
    cycle();
    checks++;
    if (obs_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", obs_valid); else passed++;
    checks++;
    if (obs_fd !== 1'b0) $display("FAIL reset_frame_done got %b want 0", obs_fd); else passed++;
    checks++;
    if (obs_win !== '0) $display("FAIL reset_out_win got %h want 0", obs_win); else passed++;
    checks++;
    if (obs_idx !== '0) $display("FAIL reset_out_idx got %0d want 0", obs_idx); else passed++;
  endtask

  task automatic test_ramp();
    clear_stats();
    run_pixels(NPIX, 100);
    drain(4);
    checks++;
    if (win_idx0 !== pack9(0, 1, 2, 15, 16, 17, 30, 31, 32))
      $display("FAIL ramp_first_win got %h want %h", win_idx0, pack9(0, 1, 2, 15, 16, 17, 30, 31, 32));
    else passed++;
    checks++;
    if (acc_at_idx0 != 33) $display("FAIL ramp_first_latency got %0d want 33", acc_at_idx0); else passed++;
    checks++;
    if (win_idx13 !== pack9(15, 16, 17, 30, 31, 32, 45, 46, 47))
      $display("FAIL row_wrap_win got %h want %h", win_idx13, pack9(15, 16, 17, 30, 31, 32, 45, 46, 47));
    else passed++;
    checks++;
    if (win_cnt != NWIN) $display("FAIL ramp_count got %0d want %0d", win_cnt, NWIN); else passed++;
    checks++;
    if (last_idx != NWIN - 1 || last_fd !== 1'b1)
      $display("FAIL ramp_last got %0d/%b want %0d/1", last_idx, last_fd, NWIN - 1);
    else passed++;
    checks++;
    if (fd_cnt != 1) $display("FAIL ramp_fd_count got %0d want 1", fd_cnt); else passed++;
  endtask

  task automatic test_backpressure();
    clear_stats();
    run_pixels(40, 100);
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_pixel = ramp(m_r, m_c);
      cycle();
      checks++;
      if (obs_in_ready !== 1'b0 || obs_valid !== 1'b1)
        $display("FAIL bp_stall got ready=%b valid=%b want ready=0 valid=1", obs_in_ready, obs_valid);
      else passed++;
    end
    run_pixels(NPIX - 40, 100);
    drain(4);
    checks++;
    if (win_cnt != NWIN) $display("FAIL bp_count got %0d want %0d", win_cnt, NWIN); else passed++;
  endtask

  task automatic test_gapped();
    clear_stats();
    run_pixels(NPIX, 50);
    drain(4);
    checks++;
    if (win_cnt != NWIN || fd_cnt != 1)
      $display("FAIL gapped_count got %0d/%0d want %0d/1", win_cnt, fd_cnt, NWIN);
    else passed++;
  endtask

  task automatic test_reset_mid();
    clear_stats();
    run_pixels(100, 100);
    rst_n = 1'b0;
    in_valid = 1'b1;
    cycle();
    rst_n = 1'b1;
    in_valid = 1'b0;
    cycle();
    checks++;
    if (obs_valid !== 1'b0) $display("FAIL reset_mid_valid got %b want 0", obs_valid); else passed++;
    clear_stats();
    run_pixels(NPIX, 100);
    drain(4);
    checks++;
    if (acc_at_idx0 != 33) $display("FAIL reset_mid_latency got %0d want 33", acc_at_idx0); else passed++;
    checks++;
    if (win_cnt != NWIN) $display("FAIL reset_mid_count got %0d want %0d", win_cnt, NWIN); else passed++;
  endtask

  task automatic test_back_to_back();
    clear_stats();
    run_pixels(2 * NPIX, 100);
    drain(4);
    checks++;
    if (fd_cnt != 2) $display("FAIL b2b_fd_count got %0d want 2", fd_cnt); else passed++;
    checks++;
    if (win_cnt != 2 * NWIN) $display("FAIL b2b_count got %0d want %0d", win_cnt, 2 * NWIN); else passed++;
    checks++;
    if (win_idx0 !== pack9(0, 1, 2, 15, 16, 17, 30, 31, 32))
      $display("FAIL b2b_second_first got %h want %h", win_idx0, pack9(0, 1, 2, 15, 16, 17, 30, 31, 32));
    else passed++;
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_ramp();
    test_backpressure();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/gx_window_gen.md
Name: gx_window_gen

Overview:
- Upstream feeder for the Sobel Gx convolution stage.
- Accepts a raster-order pixel stream, one pixel per handshake, for an IMG_W x IMG_H image.
- Holds the previous two rows in line buffers and emits one 3x3 window per valid output position. Only fully-interior positions are output, so a frame yields (IMG_W-2)*(IMG_H-2) windows.
- Each window carries its linear result index, so the Gx stage can write directly into its result memory.

Parameters:
- PIX_W, 8, pixel width in bits
- IMG_W, 15, image width in pixels (minimum 3)
- IMG_H, 15, image height in pixels (minimum 3)
- IDX_W, $clog2((IMG_W-2)*(IMG_H-2)), width of the output index

Ports:
- Clk, in, 1, clock; all logic on rising edge
- Reset, in, 1, synchronous, active-low reset
- in_pixel, in, PIX_W, incoming pixel, raster order
- in_valid, in, 1, in_pixel is valid
- in_ready, out, 1, block accepts in_pixel this cycle
- out_win, out, 9*PIX_W, taps p1..p9; tap k occupies bits [k*PIX_W-1:(k-1)*PIX_W]
- out_idx, out, IDX_W, result index = (r-2)*(IMG_W-2)+(c-2)
- out_valid, out, 1, out_win/out_idx are valid
- out_ready, in, 1, downstream accepts the window
- frame_done, out, 1, asserted together with the last window of a frame

Behaviour:
- **Reset** (Reset==0 at a rising edge):
  - out_valid=0, frame_done=0, out_win=0, out_idx=0.
  - Row/column counters cleared to 0; FSM goes to FILL.
  - Line-buffer contents are don't-care.
  - in_ready=0 during the reset cycle.
  - Reset mid-frame abandons the partial frame; no window from it appears afterwards.
- **Handshake:**
  - Input accepted when in_valid && in_ready.
  - Output transferred when out_valid && out_ready.
  - in_ready = Reset && (!out_valid || out_ready), i.e. a single output register with pass-through backpressure.
  - While out_valid=1 and out_ready=0, out_win, out_idx and frame_done stay stable.
- **Counters:**
  - col counts 0..IMG_W-1; at IMG_W-1 it wraps to 0 and row increments.
  - row counts 0..IMG_H-1; after pixel (IMG_H-1, IMG_W-1) both wrap to 0 and the next frame starts immediately.
  - Counters advance only on accepted pixels.
- **Line buffers:**
  - Two buffers of depth IMG_W hold rows r-1 and r-2.
  - On accepting pixel (r,c): read both buffers at column c, then shift.
  - The 3x3 shift register shifts left by one column per accepted pixel, with the new column {lb2[c], lb1[c], in_pixel}.
- **Window emission:**
  - When pixel (r,c) is accepted with r>=2 and c>=2, the next cycle sets out_valid=1. Latency is 1 cycle from the accepting edge.
  - Taps: p1=img[r-2][c-2], p2=img[r-2][c-1], p3=img[r-2][c], p4=img[r-1][c-2], p5=img[r-1][c-1], p6=img[r-1][c], p7=img[r][c-2], p8=img[r][c-1], p9=img[r][c].
  - Pixels with c<2 or r<2 produce no window. Stale shift-register columns from the previous row must never leak into an emitted window.
  - out_valid clears after a transfer unless a new window is loaded in the same cycle (back-to-back allowed).
- **FSM:**
  - FILL (row<2): no output. Goes to STREAM when the last pixel of row 1 is accepted.
  - STREAM (row>=2): emits windows as above. When the last pixel of the frame is accepted, the window is emitted with frame_done=1 and the FSM returns to FILL.
  - frame_done clears on the transfer of that window.
- **Arithmetic:**
  - out_idx is computed from counters, not incremented, so no wrap error is possible.
  - No arithmetic is performed on pixel data.
- **Simultaneous events:** Reset has priority over every handshake.

Test Plan:
- **Ramp frame:** 15x15 frame, pixel=(r*15+c) mod 256, out_ready=1, in_valid=1 continuously. The 33rd accepted pixel (value 32) gives, one cycle later, out_idx=0 with taps p1..p9 = 0,1,2,15,16,17,30,31,32. Exactly 169 windows in total; the last has out_idx=168 and frame_done=1.
- **Row wrap:** in the same ramp frame, pixels (3,0) and (3,1) produce no out_valid. Pixel (3,2) gives out_idx=13 with taps 15,16,17,30,31,32,45,46,47.
- **Backpressure:** hold out_ready=0 for 5 cycles while out_valid=1. Required: out_win and out_idx stable, in_ready=0, no pixel lost; the window sequence afterwards is identical to the no-stall run.
- **Gapped input:** in_valid toggled randomly 50% over the ramp frame. The window sequence and values must match the gapless run.
- **Reset mid-frame:** assert Reset=0 for 1 cycle after 100 accepted pixels. Required: out_valid=0 the following cycle. A fresh frame then gives its first window (out_idx=0) only after its own 33rd pixel.
- **Back-to-back frames:** two ramp frames with no gap. The second frame's first window has out_idx=0 and taps 0,1,2,15,16,17,30,31,32, and frame_done pulses exactly twice.
